img_pixel_feeder: RTL and testbench
===================================

# img_pixel_feeder

Upstream feeder stage for the image wrapper subsystem. It accepts 8-bit pixel bytes with a start-of-frame marker from the camera/readout path and buffers them in a small FIFO. It aligns them to frame boundaries and hands them one byte at a time to the image wrapper's byte-write slave, using a one-cycle begin strobe and an active-low response. It counts pixels per frame and reports frame completion, resynchronisation, and response-timeout errors.

## Interface

**Parameters**
- `IMG_W`, 640: pixels per line.
- `IMG_H`, 480: lines per frame.
- `FIFO_DEPTH`, 16: input FIFO entries; must be a power of 2, at least 4.
- `TIMEOUT`, 1023: maximum WAIT cycles per byte before forced advance; range 1..65535.

**Ports**
- `clk_clk` in 1: the single clock; all logic is on its rising edge.
- `reset_reset` in 1: asynchronous, active-high reset.
- `s_pix_data` in 8: input pixel byte.
- `s_pix_sof` in 1: qualifies `s_pix_data` as the first pixel of a frame.
- `s_pix_valid` in 1: input byte valid.
- `s_pix_ready` out 1: FIFO can accept a byte.
- `m_writedata` out 8: byte presented to the image wrapper's write data input.
- `m_begin` out 1: one-cycle strobe per byte; drives the wrapper's begin-burst-transfer input.
- `m_resp_n` in 1: active-low byte acknowledge, from the wrapper's write-response-valid_n.
- `busy` out 1: high while a frame is in progress.
- `frame_done` out 1: one-cycle pulse after the last byte of a frame is acknowledged.
- `err_sync` out 1: sticky flag; an SOF byte arrived mid-frame.
- `err_timeout` out 1: sticky flag; a byte was not acknowledged within `TIMEOUT` cycles.

## Operation

**FIFO**
- Width 9 bits: `{sof, data}`.
- Push when `s_pix_valid && s_pix_ready`.
- `s_pix_ready = !full`. It is combinational from the occupancy count.
- A push into a full FIFO cannot occur.
- Simultaneous push and pop leaves the count unchanged.
- Pointers wrap modulo `FIFO_DEPTH`.

**State machine: IDLE, LOAD, ISSUE, WAIT**
- **IDLE**
  - FIFO empty: stay in IDLE.
  - Head has `sof=0`: pop and discard it; stay in IDLE.
  - Head has `sof=1`: clear `x` and `y`, raise `busy`, go to LOAD without popping.
- **LOAD** (requires a non-empty FIFO; otherwise stay in LOAD)
  - Head has `sof=1` and `x|y != 0`: set `err_sync`, clear `x` and `y`, and continue using this byte as pixel 0 of the new frame.
  - Otherwise: latch head data into `m_writedata`, pop, go to ISSUE.
- **ISSUE**: `m_begin=1` for exactly this cycle, then go to WAIT. `m_resp_n` is ignored in this cycle.
- **WAIT**
  - Sample `m_resp_n` each cycle. On `m_resp_n==0`, the byte is acknowledged.
  - If the wait counter reaches `TIMEOUT` first, set `err_timeout` and treat the byte as acknowledged.
  - On acknowledge:
    - If `x==IMG_W-1`: set `x=0`, `y=y+1`.
    - Otherwise: `x=x+1`.
    - If the byte was the last pixel (`x==IMG_W-1 && y==IMG_H-1`): pulse `frame_done`, drop `busy`, go to IDLE.
    - Otherwise go to LOAD.
- **Counter widths**: `x` and `y` are `$clog2` of `IMG_W` and `IMG_H`. The wait counter is 16 bits and is cleared on entry to WAIT.
- **Error flags**: `err_sync` and `err_timeout` clear only on reset.
- **`m_writedata`** holds its value outside LOAD.

**Reset**
- Asserting `reset_reset` at any time forces IDLE and empties the FIFO.
- All outputs go to 0: `s_pix_ready`, `m_writedata`, `m_begin`, `busy`, `frame_done`, `err_sync`, `err_timeout`.
- `s_pix_ready` rises in the first cycle after deassertion.
- A partially delivered frame is abandoned. No `frame_done` is issued for it.

## Timing

- **Push to strobe latency**: a byte pushed at edge 0 into an empty FIFO, with the FSM in IDLE and SOF set, gives:
  - IDLE→LOAD at edge 1;
  - LOAD latch and pop at edge 2;
  - `m_begin` high for the cycle between edges 2 and 3.
  - Mid-frame, with the FSM already in LOAD, `m_begin` is high between edges 1 and 2.
- **Byte rate**: minimum 3 cycles per byte (LOAD, ISSUE, WAIT with `m_resp_n` low in the first WAIT cycle).
- **`frame_done`**: high the cycle after the acknowledging edge of the last pixel.
- **Timeout**: forced acknowledge occurs on the `TIMEOUT`-th WAIT cycle. `err_timeout` is visible from the next cycle.
- **`m_begin`** is never high in two consecutive cycles.

## Test plan

All scenarios use `IMG_W=4`, `IMG_H=2`, `FIFO_DEPTH=4`, `TIMEOUT=8`.

1. Send an 8-byte frame 0x10..0x17 with SOF on 0x10, and hold `m_resp_n` low. Required: 8 `m_begin` pulses carrying 0x10..0x17 in order, 3 cycles apart; a single `frame_done` after the 8th byte; `busy` low afterwards.
2. Send bytes 0xAA and 0xBB without SOF, then a valid frame. Required: 0xAA and 0xBB are discarded; the first `m_begin` carries the SOF byte; no error flags set.
3. Hold `m_resp_n` high while streaming. Required: `s_pix_ready` drops after 4 buffered bytes, and no byte is lost once `m_resp_n` is released.
4. Send SOF at pixel 3 of a frame. Required: `err_sync=1`; the SOF byte is issued as pixel 0; `frame_done` fires only after 8 further bytes.
5. Never acknowledge pixel 0. Required: `err_timeout=1` at WAIT cycle 8 plus 1; the FSM advances to pixel 1.
6. Assert `reset_reset` mid-WAIT on pixel 5. Required: all outputs are 0 immediately; the FIFO is empty; no `frame_done`; the next SOF frame completes normally.

Source files
------------

// File: rtl/img_pixel_feeder.sv
// img_pixel_feeder: buffers {sof, pixel} bytes in a small FIFO, aligns them to
// frame boundaries and hands them one at a time to a byte-write slave using a
// one-cycle begin strobe and an active-low acknowledge with a bounded wait.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | no frame in progress; drop bytes until an SOF reaches the head
// ST_LOAD  | frame in progress; latch the head byte and pop it
// ST_ISSUE | m_begin high for this single cycle
// ST_WAIT  | waiting for m_resp_n low, or for the wait counter to time out
module img_pixel_feeder #(
  parameter int IMG_W      = 640,
  parameter int IMG_H      = 480,
  parameter int FIFO_DEPTH = 16,
  parameter int TIMEOUT    = 1023
) (
  input  logic       clk_clk,
  input  logic       reset_reset,
  input  logic [7:0] s_pix_data,
  input  logic       s_pix_sof,
  input  logic       s_pix_valid,
  output logic       s_pix_ready,
  output logic [7:0] m_writedata,
  output logic       m_begin,
  input  logic       m_resp_n,
  output logic       busy,
  output logic       frame_done,
  output logic       err_sync,
  output logic       err_timeout
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  localparam logic [AW:0]   FULL_CNT = FIFO_DEPTH[AW:0];
  localparam logic [XW-1:0] X_MAX    = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_MAX    = YW'(IMG_H - 1);
  localparam logic [15:0]   WAIT_MAX = 16'(TIMEOUT - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_ISSUE = 2'd2;
  localparam logic [1:0] ST_WAIT  = 2'd3;

  logic [8:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          rdy_q;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic [8:0]    head;

  logic [1:0]    state;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [15:0]   wcnt;
  logic          ack;
  logic          x_last;
  logic          y_last;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  // rdy_q keeps ready low through reset and rises on the first edge after it
  assign s_pix_ready = rdy_q && !full;
  assign push  = s_pix_valid && s_pix_ready;
  assign head  = mem[rd_ptr];

  assign x_last  = (x == X_MAX);
  assign y_last  = (y == Y_MAX);
  assign ack     = !m_resp_n || (wcnt == WAIT_MAX);
  assign m_begin = (state == ST_ISSUE);

  // Pop on discard in IDLE and on every latch in LOAD.
  always_comb begin
    pop = 1'b0;
    if (!empty) begin
      if (state == ST_IDLE)      pop = !head[8];
      else if (state == ST_LOAD) pop = 1'b1;
    end
  end

  // FIFO storage; contents need no reset because occupancy gates every read.
  always_ff @(posedge clk_clk) begin
    if (push) mem[wr_ptr] <= {s_pix_sof, s_pix_data};
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-2 depth.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      rdy_q  <= 1'b0;
    end else begin
      rdy_q <= 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Frame sequencing, pixel position tracking and sticky error flags.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state       <= ST_IDLE;
      x           <= '0;
      y           <= '0;
      wcnt        <= '0;
      m_writedata <= '0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      err_sync    <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!empty && head[8]) begin
            x     <= '0;
            y     <= '0;
            busy  <= 1'b1;
            state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (!empty) begin
            // A fresh SOF mid-frame restarts the frame with this byte as pixel 0.
            if (head[8] && (x != '0 || y != '0)) begin
              err_sync <= 1'b1;
              x        <= '0;
              y        <= '0;
            end
            m_writedata <= head[7:0];
            state       <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          wcnt  <= '0;
          state <= ST_WAIT;
        end
        default: begin
          if (ack) begin
            if (m_resp_n) err_timeout <= 1'b1;
            if (x_last) begin
              x <= '0;
              y <= y + 1'b1;
            end else begin
              x <= x + 1'b1;
            end
            if (x_last && y_last) begin
              frame_done <= 1'b1;
              busy       <= 1'b0;
              state      <= ST_IDLE;
            end else begin
              state <= ST_LOAD;
            end
          end else begin
            wcnt <= wcnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_img_pixel_feeder.sv
// Bench for img_pixel_feeder: directed frames plus randomized streams checked
// against a frame-level model of which bytes must reach the write slave.
module tb_img_pixel_feeder;

  localparam int W    = 4;
  localparam int H    = 2;
  localparam int D    = 4;
  localparam int TO   = 8;
  localparam int NPIX = W * H;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] s_pix_data = '0;
  logic       s_pix_sof = 1'b0;
  logic       s_pix_valid = 1'b0;
  logic       s_pix_ready;
  logic [7:0] m_writedata;
  logic       m_begin;
  logic       m_resp_n = 1'b1;
  logic       busy;
  logic       frame_done;
  logic       err_sync;
  logic       err_timeout;

  img_pixel_feeder #(.IMG_W(W), .IMG_H(H), .FIFO_DEPTH(D), .TIMEOUT(TO)) dut (
    .clk_clk     (clk),
    .reset_reset (rst),
    .s_pix_data  (s_pix_data),
    .s_pix_sof   (s_pix_sof),
    .s_pix_valid (s_pix_valid),
    .s_pix_ready (s_pix_ready),
    .m_writedata (m_writedata),
    .m_begin     (m_begin),
    .m_resp_n    (m_resp_n),
    .busy        (busy),
    .frame_done  (frame_done),
    .err_sync    (err_sync),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [7:0] got[$];
  int         beg_cyc[$];
  logic [8:0] in_q[$];
  logic [7:0] exp_q[$];
  int         fd_cnt = 0;
  int         fd_cyc = 0;
  int         dbl = 0;
  bit         prev_begin = 0;
  int         exp_fd;
  bit         exp_sync;
  bit         exp_busy;
  int         resp_mode = 0;
  int         streak = 0;
  int         last_push_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Observe the write port: issued bytes, strobe timing, frame completions.
  always @(negedge clk) begin
    if (!rst) begin
      if (m_begin) begin
        got.push_back(m_writedata);
        beg_cyc.push_back(cyc);
        if (prev_begin) dbl++;
      end
      if (frame_done) begin
        fd_cnt++;
        fd_cyc = cyc;
      end
    end
    prev_begin = m_begin;
  end

  // Write slave response: 0 = always ack, 1 = never ack, 2 = random with bounded stall.
  always @(negedge clk) begin
    if (resp_mode == 0) begin
      m_resp_n = 1'b0;
    end else if (resp_mode == 1) begin
      m_resp_n = 1'b1;
    end else if (streak >= 3) begin
      m_resp_n = 1'b0;
      streak = 0;
    end else begin
      m_resp_n = ($urandom_range(0, 2) == 0);
      streak = m_resp_n ? streak + 1 : 0;
    end
  end

  initial begin
    #500us;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_neg();
    @(negedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ready"}, s_pix_ready, 0);
    check({tag, "_wdata"}, m_writedata, 0);
    check({tag, "_begin"}, m_begin, 0);
    check({tag, "_busy"},  busy, 0);
    check({tag, "_fdone"}, frame_done, 0);
    check({tag, "_esync"}, err_sync, 0);
    check({tag, "_etout"}, err_timeout, 0);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    s_pix_valid = 1'b0;
    wait_neg();
    check_zero({tag, "_rst"});
    wait_neg();
    got.delete();
    beg_cyc.delete();
    in_q.delete();
    fd_cnt = 0;
    dbl = 0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check({tag, "_ready_pre_edge"}, s_pix_ready, 0);
    wait_neg();
    check({tag, "_ready_post_rst"}, s_pix_ready, 1);
  endtask

  task automatic push(input bit sof, input logic [7:0] d);
    int n = 0;
    s_pix_valid = 1'b1;
    s_pix_sof   = sof;
    s_pix_data  = d;
    while (!s_pix_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!s_pix_ready) begin
      check("push_accept", s_pix_ready, 1);
      s_pix_valid = 1'b0;
      return;
    end
    @(negedge clk);
    in_q.push_back({sof, d});
    last_push_cyc = cyc;
    s_pix_valid = 1'b0;
  endtask

  // Frame-level model: bytes before the first SOF vanish, a frame is NPIX
  // bytes long, and an SOF inside a frame restarts it from that byte.
  task automatic run_model();
    int pos = 0;
    bit in_frame = 0;
    exp_q.delete();
    exp_fd = 0;
    exp_sync = 0;
    foreach (in_q[i]) begin
      bit s;
      logic [7:0] d;
      s = in_q[i][8];
      d = in_q[i][7:0];
      if (!in_frame && !s) continue;
      if (!in_frame) begin
        in_frame = 1;
        pos = 0;
      end else if (s) begin
        exp_sync = 1;
        pos = 0;
      end
      exp_q.push_back(d);
      pos++;
      if (pos == NPIX) begin
        exp_fd++;
        in_frame = 0;
      end
    end
    exp_busy = in_frame;
  endtask

  task automatic drain_and_compare(input string tag);
    run_model();
    for (int i = 0; i < 4000 && got.size() < exp_q.size(); i++) wait_neg();
    repeat (20) wait_neg();
    check({tag, "_nbytes"}, got.size(), exp_q.size());
    foreach (exp_q[i]) begin
      if (i < got.size()) check($sformatf("%s_byte%0d", tag, i), got[i], exp_q[i]);
    end
    check({tag, "_frames"}, fd_cnt, exp_fd);
    check({tag, "_err_sync"}, err_sync, exp_sync);
    check({tag, "_busy"}, busy, exp_busy);
    check({tag, "_no_double_begin"}, dbl, 0);
  endtask

  initial begin
    int first_cyc;
    int c0;

    // 1: clean frame, always acknowledged
    resp_mode = 0;
    do_reset("t1");
    push(1'b1, 8'h10);
    first_cyc = last_push_cyc;
    for (int i = 1; i < NPIX; i++) push(1'b0, 8'(8'h10 + i));
    drain_and_compare("t1");
    if (beg_cyc.size() == NPIX) begin
      check("t1_first_latency", beg_cyc[0], first_cyc + 2);
      for (int i = 1; i < NPIX; i++) check($sformatf("t1_gap%0d", i), beg_cyc[i] - beg_cyc[i-1], 3);
      check("t1_fd_time", fd_cyc, beg_cyc[NPIX-1] + 2);
    end else begin
      check("t1_begin_count", beg_cyc.size(), NPIX);
    end
    check("t1_err_timeout", err_timeout, 0);

    // 2: leading bytes without SOF are discarded
    do_reset("t2");
    push(1'b0, 8'hAA);
    push(1'b0, 8'hBB);
    push(1'b1, 8'h20);
    for (int i = 1; i < NPIX; i++) push(1'b0, 8'(8'h20 + i));
    drain_and_compare("t2");
    check("t2_err_timeout", err_timeout, 0);

    // 3: back-pressure while the slave stalls, then release
    resp_mode = 1;
    do_reset("t3");
    push(1'b1, 8'h30);
    for (int i = 1; i < 4; i++) push(1'b0, 8'(8'h30 + i));
    check("t3_ready_before_full", s_pix_ready, 1);
    push(1'b0, 8'h34);
    check("t3_ready_full", s_pix_ready, 0);
    resp_mode = 0;
    for (int i = 5; i < NPIX; i++) push(1'b0, 8'(8'h30 + i));
    drain_and_compare("t3");
    check("t3_err_timeout", err_timeout, 0);

    // 4: SOF at pixel 3 restarts the frame
    do_reset("t4");
    push(1'b1, 8'h40);
    push(1'b0, 8'h41);
    push(1'b0, 8'h42);
    push(1'b1, 8'h60);
    for (int i = 1; i < NPIX; i++) push(1'b0, 8'(8'h60 + i));
    drain_and_compare("t4");
    if (beg_cyc.size() > 0) check("t4_fd_time", fd_cyc, beg_cyc[beg_cyc.size()-1] + 2);

    // 5: pixel 0 never acknowledged -> forced advance on the TO-th WAIT cycle
    resp_mode = 1;
    do_reset("t5");
    push(1'b1, 8'h50);
    push(1'b0, 8'h51);
    for (int i = 0; i < 50 && got.size() < 1; i++) wait_neg();
    check("t5_first_begin_seen", got.size() >= 1, 1);
    if (got.size() >= 1) begin
      c0 = beg_cyc[0];
      check("t5_pix0", got[0], 8'h50);
      for (int i = 0; i < 50 && cyc < c0 + TO; i++) wait_neg();
      check("t5_tout_not_yet", err_timeout, 0);
      wait_neg();
      check("t5_tout_set", err_timeout, 1);
      for (int i = 0; i < 20 && got.size() < 2; i++) wait_neg();
      check("t5_second_begin_seen", got.size() >= 2, 1);
      if (got.size() >= 2) begin
        check("t5_pix1", got[1], 8'h51);
        check("t5_pix1_time", beg_cyc[1], c0 + TO + 2);
      end
    end

    // 6: reset in the middle of WAIT on pixel 5
    do_reset("t6");
    push(1'b1, 8'h70);
    for (int i = 1; i < NPIX; i++) push(1'b0, 8'(8'h70 + i));
    for (int i = 0; i < 400 && got.size() < 6; i++) wait_neg();
    check("t6_reached_pix5", got.size() >= 6, 1);
    repeat (3) wait_neg();
    rst = 1'b1;
    #1;
    check_zero("t6_async");
    resp_mode = 0;
    do_reset("t6b");
    repeat (20) wait_neg();
    check("t6_fifo_empty", got.size(), 0);
    check("t6_no_fd", fd_cnt, 0);
    check("t6_busy", busy, 0);
    push(1'b1, 8'h80);
    for (int i = 1; i < NPIX; i++) push(1'b0, 8'(8'h80 + i));
    drain_and_compare("t6b");

    // 7: randomized streams with random SOF density, gaps and response delays
    for (int r = 0; r < 2; r++) begin
      resp_mode = 2;
      do_reset("rnd");
      for (int i = 0; i < 64; i++) begin
        push($urandom_range(0, (r == 0) ? 5 : 14) == 0, 8'($urandom_range(0, 255)));
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      drain_and_compare($sformatf("rnd%0d", r));
      check($sformatf("rnd%0d_err_timeout", r), err_timeout, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
